// File: rtl/loop_pkg.sv
// loop_pkg: shared constants and types for the loop-control unit.
//   LOOP_ITER_W / LOOP_JUMP_W : default iteration-count and jump-amount widths
//   loop_desc_t               : packed descriptor {iteration_count, jump_amount}
//   loop_result_t             : branch decision carried to the fetch stage
//   loop_li_t                 : decoded loop instruction
package loop_pkg;

  localparam int LOOP_ITER_W    = 18;
  localparam int LOOP_JUMP_W    = 6;
  localparam int LOOP_NUM_LOOPS = 8;
  localparam int LOOP_NAME_W    = $clog2(LOOP_NUM_LOOPS);

  // Assembler packing order: iteration count on the MSB side.
  typedef struct packed {
    logic [LOOP_ITER_W-1:0] iteration_count;
    logic [LOOP_JUMP_W-1:0] jump_amount;
  } loop_desc_t;

  typedef struct packed {
    logic                   jump;
    logic                   last;
    logic [LOOP_JUMP_W-1:0] jump_amount;
    logic [LOOP_NAME_W-1:0] name;
    logic                   independent;
  } loop_result_t;

  typedef struct packed {
    logic [LOOP_NAME_W-1:0] name;
    logic                   independent;
    logic                   new_loop;
  } loop_li_t;

endpackage

// File: rtl/loop_desc_regfile.sv
// loop_desc_regfile: NUM_LOOPS descriptor slots, one write port, one
// combinational read port.
//   clk, rst_n          : clock, async active-low reset (clears all slots)
//   we, wr_name, wr_data: synchronous write of one packed descriptor
//   rd_name, rd_data    : combinational read; a same-cycle write is not
//                         visible until the following cycle
module loop_desc_regfile
  import loop_pkg::*;
#(
  parameter int NUM_LOOPS = LOOP_NUM_LOOPS,
  parameter int DESC_W    = LOOP_ITER_W + LOOP_JUMP_W,
  parameter int NAME_W    = $clog2(NUM_LOOPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [NAME_W-1:0] wr_name,
  input  logic [DESC_W-1:0] wr_data,
  input  logic [NAME_W-1:0] rd_name,
  output logic [DESC_W-1:0] rd_data
);

  logic [DESC_W-1:0] mem [NUM_LOOPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LOOPS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_name] <= wr_data;
    end
  end

  assign rd_data = mem[rd_name];

endmodule

// File: rtl/loop_sequencer.sv
// loop_sequencer: per-loop iteration counters plus a registered branch
// decision for each decoded loop instruction.
//   clk, rst_n                 : clock, async active-low reset
//   cfg_we/cfg_name/cfg_data   : descriptor write {iteration_count, jump_amount}
//   li_valid/li_ready          : instruction handshake
//   li_name/li_independent/li_new_loop : instruction fields
//   out_valid/out_ready        : result handshake
//   out_jump/out_jump_amount/out_last/out_name/out_independent : result
//   active                     : per-loop "iterating" bitmap
//   err                        : sticky error (continue on a loop not iterating)
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// The producer holds its payload stable while valid && !ready; valid does not
// depend on ready. li_ready = !out_valid || out_ready, so the single output
// register streams one result per cycle without bubbles.
module loop_sequencer
  import loop_pkg::*;
#(
  parameter int NUM_LOOPS = LOOP_NUM_LOOPS,
  parameter int ITER_W    = LOOP_ITER_W,
  parameter int JUMP_W    = LOOP_JUMP_W,
  parameter int NAME_W    = $clog2(NUM_LOOPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [NAME_W-1:0]        cfg_name,
  input  logic [ITER_W+JUMP_W-1:0] cfg_data,
  input  logic                     li_valid,
  output logic                     li_ready,
  input  logic [NAME_W-1:0]        li_name,
  input  logic                     li_independent,
  input  logic                     li_new_loop,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_jump,
  output logic [JUMP_W-1:0]        out_jump_amount,
  output logic                     out_last,
  output logic [NAME_W-1:0]        out_name,
  output logic                     out_independent,
  output logic [NUM_LOOPS-1:0]     active,
  output logic                     err
);

  localparam int DESC_W = ITER_W + JUMP_W;

  logic [ITER_W-1:0] remaining [NUM_LOOPS];
  logic [DESC_W-1:0] rd_desc;
  logic [ITER_W-1:0] desc_iter;
  logic [JUMP_W-1:0] desc_jump;
  logic [ITER_W-1:0] count;
  logic              bad_continue;
  logic              take_jump;
  logic              accept;

  loop_desc_regfile #(
    .NUM_LOOPS (NUM_LOOPS),
    .DESC_W    (DESC_W),
    .NAME_W    (NAME_W)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (cfg_we),
    .wr_name (cfg_name),
    .wr_data (cfg_data),
    .rd_name (li_name),
    .rd_data (rd_desc)
  );

  assign desc_iter = rd_desc[DESC_W-1:JUMP_W];
  assign desc_jump = rd_desc[JUMP_W-1:0];

  assign li_ready = !out_valid || out_ready;
  assign accept   = li_valid && li_ready;

  // A continue on a loop that is not iterating behaves like count 0.
  // While a loop is active its remaining count is always >= 1.
  always_comb begin
    bad_continue = 1'b0;
    count        = '0;
    if (li_new_loop) begin
      count = desc_iter;
    end else if (active[li_name]) begin
      count = remaining[li_name];
    end else begin
      bad_continue = 1'b1;
    end
    take_jump = (count > ITER_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LOOPS; i++) remaining[i] <= '0;
      active          <= '0;
      err             <= 1'b0;
      out_valid       <= 1'b0;
      out_jump        <= 1'b0;
      out_last        <= 1'b0;
      out_jump_amount <= '0;
      out_name        <= '0;
      out_independent <= 1'b0;
    end else begin
      if (accept) begin
        remaining[li_name] <= take_jump ? (count - ITER_W'(1)) : '0;
        active[li_name]    <= take_jump;
        if (bad_continue) err <= 1'b1;
        out_valid       <= 1'b1;
        out_jump        <= take_jump;
        out_last        <= !take_jump;
        out_jump_amount <= desc_jump;
        out_name        <= li_name;
        out_independent <= li_independent;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_loop_sequencer.sv
// tb_loop_sequencer: randomized and directed traffic against a reference
// model of the loop rules; expected results queue up at accept time and a
// monitor pops them when the DUT hands a result downstream.
module tb_loop_sequencer;

  localparam int NL = 8;
  localparam int IW = 18;
  localparam int JW = 6;
  localparam int NW = 3;
  localparam int W  = 1 + 1 + JW + NW + 1 + 1 + NL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [NW-1:0] cfg_name = '0;
  logic [IW+JW-1:0] cfg_data = '0;
  logic          li_valid = 1'b0;
  logic          li_ready;
  logic [NW-1:0] li_name = '0;
  logic          li_independent = 1'b0;
  logic          li_new_loop = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_jump;
  logic [JW-1:0] out_jump_amount;
  logic          out_last;
  logic [NW-1:0] out_name;
  logic          out_independent;
  logic [NL-1:0] active;
  logic          err;

  loop_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_name(cfg_name),
    .cfg_data(cfg_data), .li_valid(li_valid), .li_ready(li_ready),
    .li_name(li_name), .li_independent(li_independent),
    .li_new_loop(li_new_loop), .out_valid(out_valid), .out_ready(out_ready),
    .out_jump(out_jump), .out_jump_amount(out_jump_amount),
    .out_last(out_last), .out_name(out_name),
    .out_independent(out_independent), .active(active), .err(err)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // reference model: descriptor table and loop bookkeeping
  int unsigned m_iter[NL];
  int unsigned m_jump[NL];
  int unsigned m_rem[NL];
  bit          m_act[NL];
  bit          m_err;

  function automatic logic [NL-1:0] act_vec();
    logic [NL-1:0] v;
    for (int i = 0; i < NL; i++) v[i] = m_act[i];
    return v;
  endfunction

  function automatic logic [W-1:0] dut_vec();
    return {out_jump, out_last, out_jump_amount, out_name, out_independent,
            err, active};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act_v,
                       input logic [W-1:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act_v, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_iter[i] = 0; m_jump[i] = 0; m_rem[i] = 0; m_act[i] = 0;
    end
    m_err = 0;
  endtask

  // driver: one cycle of stimulus, model update on accept
  task automatic step(input bit v, input int nm, input bit ind, input bit nl,
                      input bit ordy, input bit we, input int wn,
                      input int unsigned wit, input int unsigned wj);
    bit acc;
    int unsigned c;
    bit jmp;
    @(negedge clk);
    li_valid = v; li_name = NW'(nm); li_independent = ind; li_new_loop = nl;
    out_ready = ordy;
    cfg_we = we; cfg_name = NW'(wn); cfg_data = {IW'(wit), JW'(wj)};
    #1;
    if (out_valid && !ordy)
      check("li_ready_blocked", W'(li_ready), W'(0));
    acc = v && li_ready;
    if (acc) begin
      if (nl) c = m_iter[nm];
      else if (m_act[nm]) c = m_rem[nm];
      else begin c = 0; m_err = 1; end
      jmp = (c > 1);
      m_rem[nm] = jmp ? c - 1 : 0;
      m_act[nm] = jmp;
      exp_q.push_back({jmp, !jmp, JW'(m_jump[nm]), NW'(nm), ind, m_err,
                       act_vec()});
    end
    // descriptor write lands after the accept has read the old value
    if (we) begin
      m_iter[wn] = wit & ((1 << IW) - 1);
      m_jump[wn] = wj & ((1 << JW) - 1);
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic cfg(input int wn, input int unsigned wit, input int unsigned wj);
    step(0, 0, 0, 0, 1, 1, wn, wit, wj);
  endtask

  task automatic issue(input int nm, input bit nl);
    step(1, nm, nm[0], nl, 1, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    li_valid = 0; cfg_we = 0; out_ready = 1;
    exp_q.delete();
    model_reset();
    #2;
    check("reset_outputs", W'({out_valid, out_jump, out_last, out_jump_amount,
                                out_name, out_independent, active, err}), W'(0));
    check("reset_li_ready", W'(li_ready), W'(1));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int budget;
    budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      idle();
      budget--;
    end
    if (exp_q.size() != 0)
      check("drain_timeout", W'(exp_q.size()), W'(0));
  endtask

  // monitor: pops on each downstream transfer, checks hold stability
  logic [W-1:0] held;
  bit           holding = 0;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (out_valid) begin
        if (holding) check("hold_stable", dut_vec(), held);
        if (out_ready) begin
          holding = 0;
          if (exp_q.size() == 0) check("unexpected_out", W'(1), W'(0));
          else check("result", dut_vec(), exp_q.pop_front());
        end else begin
          holding = 1;
          held = dut_vec();
        end
      end else begin
        holding = 0;
      end
    end
  end

  initial begin
    int nm;
    bit nl;
    model_reset();
    #2;
    check("por_outputs", W'({out_valid, active, err}), W'(0));
    check("por_li_ready", W'(li_ready), W'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(); idle();

    // basic 3-iteration loop
    cfg(2, 3, 5);
    issue(2, 1); issue(2, 0); issue(2, 0);
    drain();

    // iteration counts 0 and 1 fall straight through
    cfg(3, 0, 9); cfg(5, 1, 17);
    issue(3, 1); issue(5, 1);
    drain();

    // backpressure: results held, counter moves once per accept
    cfg(6, 4, 33);
    step(1, 6, 1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 6, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 6, 1, 0, 1, 0, 0, 0, 0);
    drain();

    // nested loops, plus same-cycle descriptor rewrite of slot 1
    cfg(0, 2, 1); cfg(1, 3, 2);
    issue(1, 1); issue(0, 1); issue(0, 0);
    step(1, 1, 1, 0, 1, 1, 1, 7, 40);
    issue(1, 0);
    issue(1, 1);
    drain();

    // continue on an inactive loop sets the sticky error
    issue(4, 0);
    issue(2, 1); issue(2, 0);
    drain();

    // reset in the middle of a loop
    cfg(2, 5, 3);
    issue(2, 1); issue(2, 0);
    do_reset();
    idle(); idle();
    check("post_reset_quiet", W'({out_valid, active, err}), W'(0));

    // random traffic, new_loop forced on inactive names
    for (int i = 0; i < NL; i++) cfg(i, $urandom_range(0, 6), $urandom_range(0, 63));
    for (int i = 0; i < 400; i++) begin
      nm = $urandom_range(0, NL - 1);
      nl = m_act[nm] ? ($urandom_range(0, 4) == 0) : 1'b1;
      step($urandom_range(0, 3) != 0, nm, $urandom_range(0, 1), nl,
           $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, NL - 1), $urandom_range(0, 6), $urandom_range(0, 63));
    end
    drain();

    // random traffic with unconstrained new_loop
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, NL - 1),
           $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, NL - 1), $urandom_range(0, 5), $urandom_range(0, 63));
    end
    drain();
    idle(); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
